// File: rtl/jzjpcc_mdu_pkg.sv
// Shared types and decode helpers for the execute-stage multiply/divide unit.
package jzjpcc_mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    function automatic logic is_div(input logic [2:0] f);
        return f[2];
    endfunction

    // Returns {rs1 signed, rs2 signed}
    function automatic logic [1:0] op_signs(input logic [2:0] f);
        case (f)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: return 2'b11;
            OP_MULHSU:                       return 2'b10;
            default:                         return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/jzjpcc_mdu_divstep.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module jzjpcc_mdu_divstep
    import jzjpcc_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic            qbit_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem_i < div_i always holds, so a borrow shows up exactly in the top bit
    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, div_i};
    assign qbit_o  = ~diff[XLEN];
    assign rem_o   = qbit_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/jzjpcc_execute_mdu.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes on both sides.
// Define JZJPCC_MDU_EARLY_OUT_EN to end multiplies once the multiplier is exhausted.
module jzjpcc_execute_mdu
    import jzjpcc_mdu_pkg::*;
#(
    parameter int XLEN               = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      rdAddr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      out_rdAddr,
    output logic            busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_BITS_PER_CYCLE);
    localparam logic [CW-1:0] DIV_LAST = CW'(XLEN);

    mdu_state_t        state_q;
    mdu_op_t           op_q;
    logic              neg_a_q, neg_b_q, out_valid_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d, result_q;
    logic [4:0]        rd_q;

    // Operand decode at accept time
    logic [1:0]      sgn;
    logic            a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, spec_res;

    assign sgn      = op_signs(funct3);
    assign a_neg    = sgn[1] & rs1[XLEN-1];
    assign b_neg    = sgn[0] & rs2[XLEN-1];
    assign a_mag    = a_neg ? -rs1 : rs1;
    assign b_mag    = b_neg ? -rs2 : rs2;
    assign div_zero = (rs2 == '0);
    assign div_ovf  = sgn[1] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2);
    assign spec_res = funct3[1] ? (div_zero ? rs1 : '0) : (div_zero ? '1 : rs1);

    // Shift-add multiply: multiplicand moves left, multiplier drains right
    always_comb begin
        acc_d = acc_q;
        for (int b = 0; b < MUL_BITS_PER_CYCLE; b++)
            if (mplier_q[b]) acc_d = acc_d + (mcand_q << b);
        mcand_d  = mcand_q << MUL_BITS_PER_CYCLE;
        mplier_d = mplier_q >> MUL_BITS_PER_CYCLE;
    end

    // Divide reuses the datapath: acc low half = remainder, mplier = dividend/quotient, mcand = divisor
    logic [XLEN-1:0] rem_nxt;
    logic            qbit;

    jzjpcc_mdu_divstep #(.XLEN(XLEN)) u_divstep (
        .rem_i  (acc_q[XLEN-1:0]),
        .bit_i  (mplier_q[XLEN-1]),
        .div_i  (mcand_q[XLEN-1:0]),
        .rem_o  (rem_nxt),
        .qbit_o (qbit)
    );

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;
    logic              mul_done, calc_done;

    assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    assign quo_fix  = (neg_a_q ^ neg_b_q) ? -mplier_q : mplier_q;
    assign rem_fix  = neg_a_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];

    always_comb begin
        case (op_q)
            OP_MUL:                      fin_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             fin_res = quo_fix;
            default:                     fin_res = rem_fix;
        endcase
    end

`ifdef JZJPCC_MDU_EARLY_OUT_EN
    // Product is already aligned in acc, so stopping early changes nothing but latency
    assign mul_done = (cnt_q == MUL_LAST) || (mplier_q == '0);
`else
    assign mul_done = (cnt_q == MUL_LAST);
`endif
    assign calc_done = is_div(op_q) ? (cnt_q == DIV_LAST) : mul_done;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_q        <= OP_MUL;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            result_q    <= '0;
            rd_q        <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    op_q     <= mdu_op_t'(funct3);
                    rd_q     <= rdAddr;
                    neg_a_q  <= a_neg;
                    neg_b_q  <= b_neg;
                    cnt_q    <= '0;
                    acc_q    <= '0;
                    if (is_div(funct3)) begin
                        mcand_q  <= {{XLEN{1'b0}}, b_mag};
                        mplier_q <= a_mag;
                    end else begin
                        mcand_q  <= {{XLEN{1'b0}}, a_mag};
                        mplier_q <= b_mag;
                    end
                    if (is_div(funct3) && (div_zero || div_ovf)) begin
                        result_q    <= spec_res;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        state_q <= CALC;
                    end
                end
                CALC: if (calc_done) begin
                    result_q    <= fin_res;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                    if (is_div(op_q)) begin
                        acc_q    <= {{XLEN{1'b0}}, rem_nxt};
                        mplier_q <= {mplier_q[XLEN-2:0], qbit};
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= mcand_d;
                        mplier_q <= mplier_d;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign out_rdAddr = rd_q;

endmodule

// File: tb/tb_jzjpcc_execute_mdu.sv
// Scoreboard bench for jzjpcc_execute_mdu: directed RV32M corner cases, handshakes, flush, reset.
`timescale 1ns/1ps
module tb_jzjpcc_execute_mdu;
    import jzjpcc_mdu_pkg::*;

    localparam int XLEN = 32;
    localparam int BPC  = 1;

    logic        clock, reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2, result;
    logic [4:0]  rdAddr, out_rdAddr;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct { logic [31:0] res; logic [4:0] rd; int lat; } exp_t;
    exp_t sb[$];

    jzjpcc_execute_mdu #(.XLEN(XLEN), .MUL_BITS_PER_CYCLE(BPC)) dut (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .rdAddr(rdAddr), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .out_rdAddr(out_rdAddr), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    // Reference arithmetic built from the simulator's own operators
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb2, p;
        logic [63:0] up;
        logic signed [31:0] x, y;
        logic ovf;
        sa = {{32{a[31]}}, a}; sb2 = {{32{b[31]}}, b};
        x = a; y = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'b000: begin p = sa * sb2; return p[31:0]; end
            3'b001: begin p = sa * sb2; return p[63:32]; end
            3'b010: begin p = sa * $signed({32'b0, b}); return p[63:32]; end
            3'b011: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(x / y);
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : ovf ? 32'h0 : 32'(x % y);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Edges after the accept edge until out_valid is seen; special divides reach DONE on the accept edge
    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag;
        int n;
        if (f[2]) begin
            if (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 0;
            return XLEN + 1;
        end
`ifdef JZJPCC_MDU_EARLY_OUT_EN
        mag = ((f == 3'b000 || f == 3'b001) && b[31]) ? -b : b;
        n = 0;
        while (mag != 0) begin mag = mag >> BPC; n++; end
        return n + 1;
`else
        mag = b; n = 0;
        return XLEN / BPC + 1 + n + 0 * int'(mag[0]);
`endif
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 100) begin @(posedge clock); #1; w++; end
        in_valid = 1'b1; funct3 = f; rs1 = a; rs2 = b; rdAddr = rd;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc, output bit saw_rdy);
        cyc = 0;
        saw_rdy = (in_ready === 1'b1);
        while (out_valid !== 1'b1 && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
            if (in_ready === 1'b1) saw_rdy = 1'b1;
        end
    endtask

    task automatic test_reset();
        n_chk++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_chk++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_chk++; if (result !== 32'h0)   begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        n_chk++; if (out_rdAddr !== 5'h0) begin n_fail++; $display("FAIL reset_rd got %h want 0", out_rdAddr); end
    endtask

    task automatic test_directed();
        logic [2:0]  tf [12];
        logic [31:0] ta [12], tb [12], te [12];
        int cyc;
        bit saw;
        exp_t e;
        tf = '{3'b000, 3'b011, 3'b010, 3'b001, 3'b000, 3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b101};
        ta = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd3, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
               32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        tb = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'h8000_0000, 32'd5, 32'd2, 32'd2,
               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd16};
        te = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000, 32'd15, 32'hFFFF_FFFD,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'h8000_0000, 32'h0, 32'h0FFF_FFFF};
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            sb.push_back('{res: te[i], rd: 5'(i + 1), lat: exp_lat(tf[i], ta[i], tb[i])});
            issue(tf[i], ta[i], tb[i], 5'(i + 1));
            wait_valid(cyc, saw);
            e = sb.pop_front();
            n_chk++; if (cyc !== e.lat) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, cyc, e.lat); end
            n_chk++; if (saw !== 1'b0) begin n_fail++; $display("FAIL dir%0d_in_ready_low got ready=1 want 0", i); end
            n_chk++; if (result !== e.res) begin n_fail++; $display("FAIL dir%0d_result got %h want %h", i, result, e.res); end
            n_chk++; if (out_rdAddr !== e.rd) begin n_fail++; $display("FAIL dir%0d_rd got %h want %h", i, out_rdAddr, e.rd); end
            @(posedge clock); #1;
            n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++;
                $display("FAIL dir%0d_idle got rdy=%b vld=%b want 1 0", i, in_ready, out_valid); end
        end
    endtask

    task automatic test_random_back_to_back();
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [4:0]  rd;
        int cyc;
        bit saw;
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            f = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            rd = 5'($urandom);
            sb.push_back('{res: model(f, a, b), rd: rd, lat: exp_lat(f, a, b)});
            issue(f, a, b, rd);
            wait_valid(cyc, saw);
            e = sb.pop_front();
            n_chk++; if (result !== e.res) begin n_fail++;
                $display("FAIL rnd%0d_result f=%0d a=%h b=%h got %h want %h", i, f, a, b, result, e.res); end
            n_chk++; if (out_rdAddr !== e.rd || cyc !== e.lat) begin n_fail++;
                $display("FAIL rnd%0d_rd_lat got rd=%h lat=%0d want rd=%h lat=%0d", i, out_rdAddr, cyc, e.rd, e.lat); end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_backpressure();
        int cyc;
        bit saw;
        exp_t e;
        out_ready = 1'b0;
        sb.push_back('{res: 32'd7, rd: 5'd9, lat: XLEN + 1});
        issue(3'b101, 32'd50, 32'd7, 5'd9);
        wait_valid(cyc, saw);
        e = sb.pop_front();
        n_chk++; if (cyc !== e.lat || result !== e.res) begin n_fail++;
            $display("FAIL bp_first got lat=%0d res=%h want lat=%0d res=%h", cyc, result, e.lat, e.res); end
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            n_chk++; if (result !== e.res || out_rdAddr !== e.rd) begin n_fail++;
                $display("FAIL bp_hold%0d got res=%h rd=%h want res=%h rd=%h", k, result, out_rdAddr, e.res, e.rd); end
            n_chk++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++;
                $display("FAIL bp_flags%0d got vld=%b rdy=%b busy=%b want 1 0 1", k, out_valid, in_ready, busy); end
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
            $display("FAIL bp_release got vld=%b rdy=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_flush();
        int cyc;
        bit saw, rose;
        exp_t e;
        out_ready = 1'b1;
        issue(3'b100, 32'd50, 32'd5, 5'd3);
        rose = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clock); #1;
            if (out_valid === 1'b1) rose = 1'b1;
        end
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        n_chk++; if (rose !== 1'b0 || out_valid !== 1'b0) begin n_fail++;
            $display("FAIL flush_no_valid got vld=%b want 0", out_valid); end
        n_chk++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++;
            $display("FAIL flush_idle got rdy=%b busy=%b want 1 0", in_ready, busy); end
        sb.push_back('{res: 32'd12, rd: 5'd4, lat: exp_lat(3'b000, 32'd3, 32'd4)});
        issue(3'b000, 32'd3, 32'd4, 5'd4);
        wait_valid(cyc, saw);
        e = sb.pop_front();
        n_chk++; if (cyc !== e.lat || result !== e.res || out_rdAddr !== e.rd) begin n_fail++;
            $display("FAIL flush_next_mul got lat=%0d res=%h rd=%h want %0d %h %h", cyc, result, out_rdAddr, e.lat, e.res, e.rd); end
        @(posedge clock); #1;
        in_valid = 1'b1; funct3 = 3'b000; rs1 = 32'd1; rs2 = 32'd1; flush = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0; flush = 1'b0;
        n_chk++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++;
            $display("FAIL flush_blocks_accept got rdy=%b busy=%b want 1 0", in_ready, busy); end
        out_ready = 1'b0;
        sb.push_back('{res: 32'hFFFF_FFFF, rd: 5'd6, lat: 0});
        issue(3'b101, 32'd100, 32'd0, 5'd6);
        wait_valid(cyc, saw);
        e = sb.pop_front();
        n_chk++; if (cyc !== e.lat || result !== e.res) begin n_fail++;
            $display("FAIL divzero_fast got lat=%0d res=%h want %0d %h", cyc, result, e.lat, e.res); end
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== e.res) begin n_fail++;
            $display("FAIL flush_in_done got vld=%b rdy=%b res=%h want 0 1 %h", out_valid, in_ready, result, e.res); end
    endtask

    task automatic test_reset_mid();
        issue(3'b000, 32'd3, 32'd4, 5'd7);
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++;
            $display("FAIL midreset_flags got vld=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy); end
        n_chk++; if (result !== 32'h0 || out_rdAddr !== 5'h0) begin n_fail++;
            $display("FAIL midreset_regs got res=%h rd=%h want 0 0", result, out_rdAddr); end
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        funct3 = 3'b000; rs1 = '0; rs2 = '0; rdAddr = '0;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        test_directed();
        test_random_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
